// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup and execute resolution signals of the branch predictor.
//   Fetch:   pcF -> predTakenF, predTargetF
//   Execute: updateE, isJumpE, pcE, takenE, targetE, predTakenE, predTargetE -> mispredictE, recoverPCE
//   Stats:   branchCount, mispredCount
//   slave = predictor side, master = pipeline side.
interface branch_predictor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  predTakenF;
    logic [ADDR_WIDTH-1:0] pcF;
    logic [ADDR_WIDTH-1:0] predTargetF;
    logic                  updateE;
    logic                  isJumpE;
    logic [ADDR_WIDTH-1:0] pcE;
    logic                  takenE;
    logic [ADDR_WIDTH-1:0] targetE;
    logic                  predTakenE;
    logic [ADDR_WIDTH-1:0] predTargetE;
    logic                  mispredictE;
    logic [ADDR_WIDTH-1:0] recoverPCE;
    logic [CNT_WIDTH-1:0]  branchCount;
    logic [CNT_WIDTH-1:0]  mispredCount;

    modport slave (
        input  pcF, updateE, isJumpE, pcE, takenE, targetE, predTakenE, predTargetE,
        output predTakenF, predTargetF, mispredictE, recoverPCE, branchCount, mispredCount
    );

    modport master (
        output pcF, updateE, isJumpE, pcE, takenE, targetE, predTakenE, predTargetE,
        input  predTakenF, predTargetF, mispredictE, recoverPCE, branchCount, mispredCount
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and branch/mispredict statistics.
//   clk, rst : clock, asynchronous active-high reset
//   bp       : branch_predictor_if.slave (fetch lookup, execute update/redirect, perf counters)
module branch_predictor #(
    parameter int         ADDR_WIDTH   = 32,
    parameter int         ENTRIES      = 16,
    parameter logic [1:0] COUNTER_INIT = 2'b01,
    parameter int         CNT_WIDTH    = 32
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;

    logic                  valid   [ENTRIES];
    logic [TAG_W-1:0]      tags    [ENTRIES];
    logic [ADDR_WIDTH-1:0] targets [ENTRIES];
    logic [1:0]            ctrs    [ENTRIES];

    logic [IDX-1:0]   idxF, idxE;
    logic [TAG_W-1:0] tagF, tagE;
    logic             hitF, hitE;

    assign idxF = bp.pcF[IDX+1:2];
    assign tagF = bp.pcF[ADDR_WIDTH-1:IDX+2];
    assign idxE = bp.pcE[IDX+1:2];
    assign tagE = bp.pcE[ADDR_WIDTH-1:IDX+2];
    assign hitF = valid[idxF] && tags[idxF] == tagF;
    assign hitE = valid[idxE] && tags[idxE] == tagE;

    // Lookup sees the table as it was before this cycle's update; no bypass.
    assign bp.predTakenF  = hitF && ctrs[idxF][1];
    assign bp.predTargetF = bp.predTakenF ? targets[idxF] : bp.pcF + ADDR_WIDTH'(4);
    assign bp.mispredictE = bp.updateE && ((bp.predTakenE != bp.takenE) ||
                                           (bp.takenE && bp.predTargetE != bp.targetE));
    assign bp.recoverPCE  = bp.takenE ? bp.targetE : bp.pcE + ADDR_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctrs[i]  <= COUNTER_INIT;
            end
            bp.branchCount  <= '0;
            bp.mispredCount <= '0;
        end else begin
            if (bp.updateE) begin
                if (hitE)
                    ctrs[idxE] <= bp.takenE ? (ctrs[idxE] == 2'd3 ? 2'd3 : ctrs[idxE] + 2'd1)
                                            : (ctrs[idxE] == 2'd0 ? 2'd0 : ctrs[idxE] - 2'd1);
                else if (bp.takenE) begin
                    valid[idxE] <= 1'b1;
                    ctrs[idxE]  <= bp.isJumpE ? 2'd3 : 2'd2;
                end
            end
            if (bp.updateE && !(&bp.branchCount))
                bp.branchCount <= bp.branchCount + CNT_WIDTH'(1);
            if (bp.mispredictE && !(&bp.mispredCount))
                bp.mispredCount <= bp.mispredCount + CNT_WIDTH'(1);
        end
    end

    // Tag/target need no reset: valid guards them. Any taken update (hit or allocate)
    // writes both; on a hit the tag is rewritten with the same value.
    always_ff @(posedge clk) begin
        if (!rst && bp.updateE && bp.takenE) begin
            tags[idxE]    <= tagE;
            targets[idxE] <= bp.targetE;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor with a queue-based reference model.
module tb_branch_predictor;
    localparam int AW = 32;
    localparam int CW = 4;
    localparam int NE = 16;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic          pt;
        logic [AW-1:0] ptg;
        logic          mis;
        logic [AW-1:0] rec;
        int            bc;
        int            mc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    // Reference model: one record per BTB line, keyed by word address modulo ENTRIES.
    bit            mValid [NE];
    logic [AW-1:0] mLinePc[NE];
    logic [AW-1:0] mTgt   [NE];
    int            mCtr   [NE];
    int            mBc, mMc;

    branch_predictor_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bp ();

    branch_predictor #(.ADDR_WIDTH(AW), .ENTRIES(NE), .COUNTER_INIT(2'b01), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp.slave)
    );

    always #5 clk = ~clk;

    function automatic int lineOf(input logic [AW-1:0] pc);
        return int'((pc / 4) % NE);
    endfunction

    // Same line and same word-address block above the line index means a hit.
    function automatic bit mHit(input logic [AW-1:0] pc);
        int l = lineOf(pc);
        return mValid[l] && (mLinePc[l] / (4 * NE)) == (pc / (4 * NE));
    endfunction

    function automatic void mReset();
        for (int i = 0; i < NE; i++) begin
            mValid[i] = 0;
            mCtr[i] = 1;
        end
        mBc = 0;
        mMc = 0;
    endfunction

    function automatic void mPredict(input logic [AW-1:0] pc, output logic t, output logic [AW-1:0] tg);
        t = mHit(pc) && mCtr[lineOf(pc)] >= 2;
        tg = t ? mTgt[lineOf(pc)] : pc + 4;
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle (called at posedge+1), queue the expected view, then advance the model.
    task automatic cyc(input logic u, input logic [AW-1:0] pf, input logic [AW-1:0] pe, input logic tk,
                       input logic [AW-1:0] tg, input logic j, input logic pt, input logic [AW-1:0] ptg);
        exp_t e;
        logic mis;
        int l;
        bp.updateE = u; bp.pcF = pf; bp.pcE = pe; bp.takenE = tk; bp.targetE = tg;
        bp.isJumpE = j; bp.predTakenE = pt; bp.predTargetE = ptg;
        if (rst) mReset();
        mis = u && (pt != tk || (tk && ptg != tg));
        mPredict(pf, e.pt, e.ptg);
        e.mis = mis;
        e.rec = tk ? tg : pe + 4;
        e.bc = mBc;
        e.mc = mMc;
        q.push_back(e);
        @(posedge clk);
        if (!rst && u) begin
            l = lineOf(pe);
            if (mHit(pe)) begin
                if (tk) begin
                    mCtr[l] = mCtr[l] == 3 ? 3 : mCtr[l] + 1;
                    mTgt[l] = tg;
                end else
                    mCtr[l] = mCtr[l] == 0 ? 0 : mCtr[l] - 1;
            end else if (tk) begin
                mValid[l] = 1;
                mLinePc[l] = pe;
                mTgt[l] = tg;
                mCtr[l] = j ? 3 : 2;
            end
            mBc = mBc < CMAX ? mBc + 1 : CMAX;
            if (mis) mMc = mMc < CMAX ? mMc + 1 : CMAX;
        end
        #1;
    endtask

    task automatic look(input logic [AW-1:0] pf);
        cyc(0, pf, 0, 0, 0, 0, 0, 0);
    endtask

    // Resolve at pc with the prediction the model says fetch made.
    task automatic res(input logic [AW-1:0] pf, input logic [AW-1:0] pe, input logic tk,
                       input logic [AW-1:0] tg, input logic j);
        logic pt;
        logic [AW-1:0] ptg;
        mPredict(pe, pt, ptg);
        cyc(1, pf, pe, tk, tg, j, pt, ptg);
    endtask

    // Monitor: every sampled cycle with a queued expectation is compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("predTakenF", AW'(bp.predTakenF), AW'(e.pt));
                chk("predTargetF", bp.predTargetF, e.ptg);
                chk("mispredictE", AW'(bp.mispredictE), AW'(e.mis));
                if (e.mis) chk("recoverPCE", bp.recoverPCE, e.rec);
                chk("branchCount", AW'(bp.branchCount), AW'(e.bc));
                chk("mispredCount", AW'(bp.mispredCount), AW'(e.mc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] pc, tg;
        logic tk, j, pt;
        logic [AW-1:0] ptg;
        mReset();
        @(posedge clk); #1;
        // In reset: lookups miss, mispredict still follows its inputs.
        cyc(1, 32'h100, 32'h100, 1, 32'h80, 0, 0, 32'h104);
        rst = 1'b0;
        look(32'h100);
        cyc(1, 32'h100, 32'h100, 1, 32'h80, 0, 0, 32'h104);
        look(32'h100);
        cyc(1, 32'h100, 32'h100, 0, 32'h0, 0, 1, 32'h80);
        look(32'h100);
        cyc(1, 32'h100, 32'h100, 0, 32'h0, 0, 0, 32'h104);
        res(32'h100, 32'h100, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) res(32'h100, 32'h100, 1, 32'h80, 0);
        look(32'h100);
        look(32'h140);
        res(32'h140, 32'h140, 1, 32'h200, 0);
        look(32'h140);
        look(32'h100);
        res(32'h20, 32'h20, 1, 32'h400, 1);
        look(32'h20);
        res(32'h20, 32'h20, 0, 32'h0, 0);
        look(32'h20);
        for (int i = 0; i < 20; i++) cyc(1, 32'h300, 32'h300, 1, 32'h500, 0, 0, 32'h304);
        look(32'h300);
        for (int i = 0; i < 5; i++) cyc(1, 32'h300, 32'h300, 1, 32'h500, 0, 0, 32'h304);
        rst = 1'b1;
        cyc(1, 32'h100, 32'h100, 1, 32'h80, 0, 0, 32'h104);
        look(32'h300);
        rst = 1'b0;
        look(32'h100);
        for (int n = 0; n < 400; n++) begin
            pc = (AW'($urandom_range(0, 3)) << 6) | (AW'($urandom_range(0, 15)) << 2) | AW'($urandom_range(0, 3));
            tg = AW'($urandom_range(0, 255)) << 2;
            j = ($urandom_range(0, 5) == 0);
            tk = j ? ($urandom_range(0, 9) != 0) : $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) begin
                pt = $urandom_range(0, 1) == 1;
                ptg = AW'($urandom_range(0, 255)) << 2;
                cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? pc : (pc ^ 32'h40), pc, tk, tg, j, pt, ptg);
            end else if ($urandom_range(0, 4) == 0)
                look(pc);
            else
                res(pc ^ (AW'($urandom_range(0, 1)) << 6), pc, tk, tg, j);
        end
        look(32'h0);
        repeat (2) @(posedge clk);
        chk("queue_drained", AW'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
